dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 31: number of valid data-memory words; addresses 0..DEPTH-1 are legal.
REQ-002 Parameter DW, default 32: data and address width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Ports p0_req / p1_req, input, 1: access request (p0 = core load/store unit, p1 = loader/debug port).
REQ-007 Ports p0_we / p1_we, input, 1: 1 = write, 0 = read; valid while the matching req is high.
REQ-008 Ports p0_addr / p1_addr, input, DW: word address.
REQ-009 Ports p0_wdata / p1_wdata, input, DW: write data.
REQ-010 Ports p0_gnt / p1_gnt, output, 1: one-cycle grant pulse.
REQ-011 Ports p0_done / p1_done, output, 1: one-cycle completion pulse.
REQ-012 Ports p0_rdata / p1_rdata, output, DW: read data, valid when the matching done is high.
REQ-013 Ports p0_err / p1_err, output, 1: out-of-range flag, valid when the matching done is high.
REQ-014 Port busy, output, 1: high while the FSM is not IDLE.
REQ-015 Ports mem_address, mem_write_data, output, DW: to the data memory.
REQ-016 Ports mem_write, mem_read, output, 1: memory strobes.
REQ-017 Port mem_data, input, DW: combinational read data from the memory.

Function
REQ-018 The FSM SHALL have two states: IDLE and ACCESS.
REQ-019 In IDLE with any req high, at the clock edge the block SHALL:
- select a winner;
- latch the winner's we, addr and wdata;
- assert the winner's gnt in the next cycle;
- go to ACCESS.
REQ-020 Arbitration SHALL be round-robin: if both req are high, the port not granted last wins; a single requester always wins.
REQ-021 In ACCESS, only the latched values SHALL drive the memory:
- mem_address = latched addr;
- mem_write = latched we;
- mem_read = !latched we.
REQ-022 In IDLE, mem_write and mem_read SHALL be 0 and mem_address / mem_write_data SHALL hold their last value (no glitching writes).
REQ-023 At the end of ACCESS, the block SHALL:
- capture mem_data into the winner's rdata (reads only);
- pulse the winner's done in the following cycle;
- return to IDLE.
REQ-024 Latency SHALL be: req sampled at edge N, gnt high in cycle N+1, strobe high in cycle N+1, done and rdata in cycle N+2. Maximum throughput is one access per 2 cycles.
REQ-025 A requester SHALL drop req at the edge where it samples gnt, unless it issues a new request. Requests arriving during ACCESS SHALL wait; no request is ever dropped.
REQ-026 An address >= DEPTH SHALL assert no memory strobe in ACCESS. Done SHALL pulse with err = 1 and rdata = 0.
REQ-027 For writes, rdata SHALL hold its previous value and err SHALL follow REQ-026.
REQ-028 The grant pointer SHALL update only when a grant is issued.
REQ-029 The outputs of the non-winning port SHALL stay unchanged.

Reset
REQ-030 Reset SHALL force:
- the FSM to IDLE;
- all gnt, done, err and strobe outputs, and busy, to 0;
- rdata and mem_address / mem_write_data to 0;
- the last-granted pointer to p1, so p0 wins the first tie.
REQ-031 Reset asserted during ACCESS SHALL abort the access: no done pulse, and strobes low from the next cycle.

Structure
REQ-032 The shared package dmem_pkg SHALL hold the state enum (IDLE, ACCESS), the DEPTH default and the port index constants.
REQ-033 The 2-way round-robin picker SHALL be a sub-module named rr_arb2 (inputs: req vector, last pointer; output: one-hot winner).

Verification
REQ-034 p0 reads addr 1 (memory word = 0x00000003) -> p0_gnt in cycle 1, p0_done in cycle 2, p0_rdata = 0x00000003, p0_err = 0.
REQ-035 p1 writes 0xDEADBEEF to addr 5, then reads addr 5 -> mem_write high for exactly 1 cycle, then p1_rdata = 0xDEADBEEF.
REQ-036 p0 and p1 request every cycle after reset -> grant order p0, p1, p0, p1; one done every 2 cycles.
REQ-037 p0 reads addr 31 -> no mem_read or mem_write, p0_done with p0_err = 1 and p0_rdata = 0.
REQ-038 reset asserted in the ACCESS cycle of a write -> no done pulse, busy = 0 and strobes = 0 the next cycle, the next request is served normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int DEPTH_DEFAULT = 31;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker producing a one-hot winner
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  // A lone requester wins outright; on a tie the port not granted last wins
  always_comb begin
    win = req;
    if (req == 2'b11) begin
      win = (last == PORT1) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of a single data memory
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [DW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_done,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [DW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_done,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic          busy,
  output logic [DW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_data
);

  localparam logic [DW-1:0] DEPTH_W = DW'(DEPTH);

  state_t        state;
  logic          last_gnt;
  logic          sel;
  logic          lat_we;
  logic          lat_oor;
  logic [1:0]    win;
  logic          pick_p1;
  logic          pick_we;
  logic          pick_oor;
  logic [DW-1:0] pick_addr;
  logic [DW-1:0] pick_wdata;

  rr_arb2 u_rr_arb2 (
    .req  ({p1_req, p0_req}),
    .last (last_gnt),
    .win  (win)
  );

  // Steer the winning port's request fields toward the latch
  always_comb begin
    pick_p1    = win[1];
    pick_we    = pick_p1 ? p1_we    : p0_we;
    pick_addr  = pick_p1 ? p1_addr  : p0_addr;
    pick_wdata = pick_p1 ? p1_wdata : p0_wdata;
    pick_oor   = (pick_addr >= DEPTH_W);
  end

  // Two-state access FSM; every output is registered so strobes never glitch
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      last_gnt       <= PORT1;
      sel            <= PORT0;
      lat_we         <= 1'b0;
      lat_oor        <= 1'b0;
      p0_gnt         <= 1'b0;
      p1_gnt         <= 1'b0;
      p0_done        <= 1'b0;
      p1_done        <= 1'b0;
      p0_err         <= 1'b0;
      p1_err         <= 1'b0;
      p0_rdata       <= '0;
      p1_rdata       <= '0;
      busy           <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
    end else begin
      p0_gnt  <= 1'b0;
      p1_gnt  <= 1'b0;
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (|win) begin
            sel            <= pick_p1 ? PORT1 : PORT0;
            last_gnt       <= pick_p1 ? PORT1 : PORT0;
            lat_we         <= pick_we;
            lat_oor        <= pick_oor;
            mem_address    <= pick_addr;
            mem_write_data <= pick_wdata;
            mem_write      <= pick_we & ~pick_oor;
            mem_read       <= ~pick_we & ~pick_oor;
            p0_gnt         <= ~pick_p1;
            p1_gnt         <= pick_p1;
            busy           <= 1'b1;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
          if (sel == PORT0) begin
            p0_done <= 1'b1;
            p0_err  <= lat_oor;
            if (!lat_we) begin
              p0_rdata <= lat_oor ? '0 : mem_data;
            end
          end else begin
            p1_done <= 1'b1;
            p1_err  <= lat_oor;
            if (!lat_we) begin
              p1_rdata <= lat_oor ? '0 : mem_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int DEPTH = 31;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_req, p0_we, p0_gnt, p0_done, p0_err;
  logic [DW-1:0] p0_addr, p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_gnt, p1_done, p1_err;
  logic [DW-1:0] p1_addr, p1_wdata, p1_rdata;
  logic          busy, mem_write, mem_read;
  logic [DW-1:0] mem_address, mem_write_data, mem_data;

  logic          mem_init;
  logic [31:0]   mem [0:63];
  logic [31:0]   ref_mem [0:63];
  int            wr_cycles = 0;
  int            n_checks;
  int            n_fail;

  dmem_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .busy(busy), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  assign mem_data = mem[mem_address[5:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(2 * i + 1);
    end else if (mem_write) begin
      mem[mem_address[5:0]] <= mem_write_data;
      wr_cycles <= wr_cycles + 1;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; mem_init = 1'b1;
    step();
    mem_init = 1'b0;
    step();
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'(2 * i + 1);
    n_checks++; if ({p0_gnt, p1_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", {p0_gnt, p1_gnt}); end
    n_checks++; if ({p0_done, p1_done} !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b expected 00", {p0_done, p1_done}); end
    n_checks++; if ({p0_err, p1_err} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b expected 00", {p0_err, p1_err}); end
    n_checks++; if ({busy, mem_write, mem_read} !== 3'b000) begin n_fail++; $display("FAIL reset_busy_strobes: got %b expected 000", {busy, mem_write, mem_read}); end
    n_checks++; if ({p0_rdata, p1_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", {p0_rdata, p1_rdata}); end
    n_checks++; if ({mem_address, mem_write_data} !== 64'h0) begin n_fail++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_address, mem_write_data}); end
    reset = 1'b0;
  endtask

  task automatic test_read_p0();
    p0_req = 1; p0_we = 0; p0_addr = 32'd1;
    step();
    n_checks++; if (p0_gnt !== 1'b1) begin n_fail++; $display("FAIL rd0_gnt: got %b expected 1", p0_gnt); end
    n_checks++; if ({busy, mem_read, mem_write} !== 3'b110) begin n_fail++; $display("FAIL rd0_strobes: got %b expected 110", {busy, mem_read, mem_write}); end
    n_checks++; if (mem_address !== 32'd1) begin n_fail++; $display("FAIL rd0_addr: got %h expected 1", mem_address); end
    p0_req = 0;
    step();
    n_checks++; if ({p0_done, p0_gnt, p1_done} !== 3'b100) begin n_fail++; $display("FAIL rd0_done: got %b expected 100", {p0_done, p0_gnt, p1_done}); end
    n_checks++; if (p0_rdata !== 32'h3) begin n_fail++; $display("FAIL rd0_rdata: got %h expected 00000003", p0_rdata); end
    n_checks++; if (p0_err !== 1'b0) begin n_fail++; $display("FAIL rd0_err: got %b expected 0", p0_err); end
    n_checks++; if ({busy, mem_read} !== 2'b00) begin n_fail++; $display("FAIL rd0_idle: got %b expected 00", {busy, mem_read}); end
  endtask

  task automatic test_write_read_p1();
    int w0;
    w0 = wr_cycles;
    p1_req = 1; p1_we = 1; p1_addr = 32'd5; p1_wdata = 32'hDEADBEEF;
    step();
    n_checks++; if ({p1_gnt, mem_write, mem_read} !== 3'b110) begin n_fail++; $display("FAIL wr1_gnt_strobe: got %b expected 110", {p1_gnt, mem_write, mem_read}); end
    n_checks++; if (mem_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr1_wdata: got %h expected deadbeef", mem_write_data); end
    p1_req = 0;
    step();
    n_checks++; if ({p1_done, p1_err, mem_write} !== 3'b100) begin n_fail++; $display("FAIL wr1_done: got %b expected 100", {p1_done, p1_err, mem_write}); end
    n_checks++; if (p1_rdata !== 32'h0) begin n_fail++; $display("FAIL wr1_rdata_hold: got %h expected 0", p1_rdata); end
    step();
    n_checks++; if (wr_cycles - w0 !== 1) begin n_fail++; $display("FAIL wr1_strobe_cycles: got %0d expected 1", wr_cycles - w0); end
    ref_mem[5] = 32'hDEADBEEF;
    p1_req = 1; p1_we = 0; p1_addr = 32'd5;
    step();
    n_checks++; if ({p1_gnt, mem_read} !== 2'b11) begin n_fail++; $display("FAIL rd1_gnt: got %b expected 11", {p1_gnt, mem_read}); end
    p1_req = 0;
    step();
    n_checks++; if (p1_done !== 1'b1 || p1_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd1_rdata: done %b data %h expected 1 deadbeef", p1_done, p1_rdata); end
  endtask

  task automatic test_round_robin();
    do_reset();
    p0_req = 1; p0_we = 0; p0_addr = 32'd2;
    p1_req = 1; p1_we = 0; p1_addr = 32'd3;
    for (int c = 1; c <= 8; c++) begin
      step();
      n_checks++; if ({p0_gnt, p1_gnt} !== {c % 4 == 1, c % 4 == 3}) begin n_fail++; $display("FAIL rr_gnt c%0d: got %b expected %b", c, {p0_gnt, p1_gnt}, {c % 4 == 1, c % 4 == 3}); end
      n_checks++; if ({p0_done, p1_done} !== {c % 4 == 2, c % 4 == 0}) begin n_fail++; $display("FAIL rr_done c%0d: got %b expected %b", c, {p0_done, p1_done}, {c % 4 == 2, c % 4 == 0}); end
      if (c % 4 == 2) begin
        n_checks++; if (p0_rdata !== 32'd5) begin n_fail++; $display("FAIL rr_p0_rdata c%0d: got %h expected 5", c, p0_rdata); end
      end
      if (c % 4 == 0) begin
        n_checks++; if (p1_rdata !== 32'd7) begin n_fail++; $display("FAIL rr_p1_rdata c%0d: got %h expected 7", c, p1_rdata); end
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_out_of_range();
    p0_req = 1; p0_we = 0; p0_addr = 32'd31;
    step();
    n_checks++; if ({p0_gnt, mem_read, mem_write} !== 3'b100) begin n_fail++; $display("FAIL oor_rd_strobes: got %b expected 100", {p0_gnt, mem_read, mem_write}); end
    p0_req = 0;
    step();
    n_checks++; if ({p0_done, p0_err} !== 2'b11 || p0_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_rd_done: done/err %b rdata %h expected 11 0", {p0_done, p0_err}, p0_rdata); end
    n_checks++; if ({p1_done, p1_err} !== 2'b00 || p1_rdata !== 32'd7) begin n_fail++; $display("FAIL oor_p1_untouched: done/err %b rdata %h expected 00 7", {p1_done, p1_err}, p1_rdata); end
    p1_req = 1; p1_we = 1; p1_addr = 32'd40; p1_wdata = 32'h55AA55AA;
    step();
    n_checks++; if ({p1_gnt, mem_write, mem_read} !== 3'b100) begin n_fail++; $display("FAIL oor_wr_strobes: got %b expected 100", {p1_gnt, mem_write, mem_read}); end
    p1_req = 0;
    step();
    n_checks++; if ({p1_done, p1_err} !== 2'b11 || p1_rdata !== 32'd7) begin n_fail++; $display("FAIL oor_wr_done: done/err %b rdata %h expected 11 7", {p1_done, p1_err}, p1_rdata); end
    n_checks++; if (p0_err !== 1'b1) begin n_fail++; $display("FAIL oor_p0_err_hold: got %b expected 1", p0_err); end
    p1_req = 1; p1_we = 0; p1_addr = 32'd30;
    step();
    p1_req = 0;
    step();
    n_checks++; if ({p1_done, p1_err} !== 2'b10 || p1_rdata !== 32'd61) begin n_fail++; $display("FAIL last_addr_rd: done/err %b rdata %h expected 10 3d", {p1_done, p1_err}, p1_rdata); end
  endtask

  task automatic test_reset_abort();
    p1_req = 1; p1_we = 1; p1_addr = 32'd7; p1_wdata = 32'h12345678;
    step();
    n_checks++; if ({p1_gnt, mem_write} !== 2'b11) begin n_fail++; $display("FAIL abort_gnt: got %b expected 11", {p1_gnt, mem_write}); end
    p1_req = 0; reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if ({p1_done, busy, mem_write, mem_read} !== 4'b0000) begin n_fail++; $display("FAIL abort_quiet: got %b expected 0000", {p1_done, busy, mem_write, mem_read}); end
    p0_req = 1; p0_we = 0; p0_addr = 32'd2;
    step();
    n_checks++; if (p1_done !== 1'b0 || p0_gnt !== 1'b1) begin n_fail++; $display("FAIL abort_next_gnt: p1_done %b p0_gnt %b expected 0 1", p1_done, p0_gnt); end
    p0_req = 0;
    step();
    n_checks++; if (p0_done !== 1'b1 || p0_rdata !== 32'd5) begin n_fail++; $display("FAIL abort_next_done: done %b rdata %h expected 1 5", p0_done, p0_rdata); end
  endtask

  task automatic test_random();
    logic        pend [2];
    logic        m_we [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd [2];
    logic        stg [2];
    logic [31:0] stg_rd [2];
    logic        stg_er [2];
    logic        exp_done [2];
    logic [31:0] exp_rd [2];
    logic        exp_er [2];
    logic        s0, s1, prev_gnt, inr;
    int          last_g, gw;

    idle_inputs();
    reset = 1'b1; mem_init = 1'b1;
    step();
    mem_init = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'(2 * i + 1);
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; m_we[p] = 0; m_addr[p] = '0; m_wd[p] = '0;
      stg[p] = 0; stg_rd[p] = '0; stg_er[p] = 0;
      exp_done[p] = 0; exp_rd[p] = '0; exp_er[p] = 0;
    end
    prev_gnt = 0;
    last_g = 1;

    for (int cyc = 0; cyc < 600; cyc++) begin
      s0 = pend[0];
      s1 = pend[1];
      step();
      for (int p = 0; p < 2; p++) begin
        exp_done[p] = stg[p];
        if (stg[p]) begin exp_rd[p] = stg_rd[p]; exp_er[p] = stg_er[p]; end
        stg[p] = 0;
      end
      gw = -1;
      if (!prev_gnt) begin
        if (s0 && s1) gw = (last_g == 1) ? 0 : 1;
        else if (s0) gw = 0;
        else if (s1) gw = 1;
      end
      n_checks++; if ({p0_gnt, p1_gnt} !== {gw == 0, gw == 1}) begin n_fail++; $display("FAIL rnd_gnt cyc %0d: got %b expected %b", cyc, {p0_gnt, p1_gnt}, {gw == 0, gw == 1}); end
      n_checks++; if ({p0_done, p1_done} !== {exp_done[0], exp_done[1]}) begin n_fail++; $display("FAIL rnd_done cyc %0d: got %b expected %b", cyc, {p0_done, p1_done}, {exp_done[0], exp_done[1]}); end
      n_checks++; if (p0_rdata !== exp_rd[0] || p0_err !== exp_er[0]) begin n_fail++; $display("FAIL rnd_p0_result cyc %0d: got %h/%b expected %h/%b", cyc, p0_rdata, p0_err, exp_rd[0], exp_er[0]); end
      n_checks++; if (p1_rdata !== exp_rd[1] || p1_err !== exp_er[1]) begin n_fail++; $display("FAIL rnd_p1_result cyc %0d: got %h/%b expected %h/%b", cyc, p1_rdata, p1_err, exp_rd[1], exp_er[1]); end
      if (gw >= 0) begin
        inr = (m_addr[gw] < 32'(DEPTH));
        n_checks++; if ({busy, mem_write, mem_read} !== {1'b1, m_we[gw] & inr, ~m_we[gw] & inr}) begin n_fail++; $display("FAIL rnd_strobes cyc %0d: got %b expected %b", cyc, {busy, mem_write, mem_read}, {1'b1, m_we[gw] & inr, ~m_we[gw] & inr}); end
        n_checks++; if (mem_address !== m_addr[gw]) begin n_fail++; $display("FAIL rnd_addr cyc %0d: got %h expected %h", cyc, mem_address, m_addr[gw]); end
        stg[gw] = 1;
        stg_er[gw] = !inr;
        stg_rd[gw] = m_we[gw] ? exp_rd[gw] : (inr ? ref_mem[m_addr[gw][5:0]] : 32'h0);
        if (m_we[gw] && inr) ref_mem[m_addr[gw][5:0]] = m_wd[gw];
        pend[gw] = 0;
        last_g = gw;
        prev_gnt = 1;
      end else begin
        n_checks++; if ({busy, mem_write, mem_read} !== 3'b000) begin n_fail++; $display("FAIL rnd_idle cyc %0d: got %b expected 000", cyc, {busy, mem_write, mem_read}); end
        prev_gnt = 0;
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]   = 1;
          m_we[p]   = 1'($urandom_range(0, 1));
          m_addr[p] = 32'($urandom_range(0, 40));
          m_wd[p]   = $urandom;
        end
      end
      p0_req = pend[0]; p0_we = m_we[0]; p0_addr = m_addr[0]; p0_wdata = m_wd[0];
      p1_req = pend[1]; p1_we = m_we[1]; p1_addr = m_addr[1]; p1_wdata = m_wd[1];
    end
    idle_inputs();
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mem_init = 1'b0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_read_p0();
    test_write_read_p1();
    test_round_robin();
    test_out_of_range();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
